// File: rtl/i2c_master_wr.sv
// Single-master I2C write engine: START, 7-bit address + W, one data byte, STOP.
// SCL is push-pull; SDA is open-drain (driven low or released only).
module i2c_master_wr #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       scl,
  inout  wire        sda
);

  localparam int unsigned DIV_W = 16;

  typedef enum logic [2:0] {
    IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       qtr, qtr_nxt;
  logic [2:0]       bitcnt, bitcnt_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic [6:0]       addr_q, addr_nxt;
  logic [7:0]       wdata_q, wdata_nxt;
  logic             busy_nxt, done_nxt, nack_nxt, scl_nxt;
  logic             sda_oe, oe_nxt;
  logic             tick, bit_nxt, sda_in;
  logic [7:0]       abyte_nxt;

  // Open-drain pad: pull low or let the external pull-up win.
  assign sda    = sda_oe ? 1'b0 : 1'bz;
  assign sda_in = sda;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      qtr     <= 2'd0;
      bitcnt  <= 3'd7;
      div     <= '0;
      addr_q  <= 7'd0;
      wdata_q <= 8'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      nack    <= 1'b0;
      scl     <= 1'b1;
      sda_oe  <= 1'b0;
    end else begin
      state   <= state_nxt;
      qtr     <= qtr_nxt;
      bitcnt  <= bitcnt_nxt;
      div     <= div_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      nack    <= nack_nxt;
      scl     <= scl_nxt;
      sda_oe  <= oe_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    qtr_nxt    = qtr;
    bitcnt_nxt = bitcnt;
    div_nxt    = div;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    nack_nxt   = nack;
    tick       = 1'b0;
    scl_nxt    = 1'b1;
    oe_nxt     = 1'b0;

    if (state == IDLE) begin
      div_nxt = '0;
      if (start) begin
        state_nxt  = START;
        qtr_nxt    = 2'd0;
        bitcnt_nxt = 3'd7;
        addr_nxt   = addr;
        wdata_nxt  = wdata;
        nack_nxt   = 1'b0;
        busy_nxt   = 1'b1;
      end
    end else begin
      tick    = (div == DIV_W'(CLK_DIV - 1));
      div_nxt = tick ? '0 : div + DIV_W'(1);
      if (tick) begin
        qtr_nxt = qtr + 2'd1;
        // Acknowledge is sampled once, at the end of the first SCL-high quarter.
        if (qtr == 2'd1 && (state == ADDR_ACK || state == DATA_ACK)) nack_nxt = sda_in;
        if (qtr == 2'd3) begin
          unique case (state)
            START: begin
              state_nxt  = ADDR;
              bitcnt_nxt = 3'd7;
            end
            ADDR: begin
              if (bitcnt == 3'd0) state_nxt = ADDR_ACK;
              else                bitcnt_nxt = bitcnt - 3'd1;
            end
            ADDR_ACK: begin
              bitcnt_nxt = 3'd7;
              state_nxt  = nack ? STOP : DATA;
            end
            DATA: begin
              if (bitcnt == 3'd0) state_nxt = DATA_ACK;
              else                bitcnt_nxt = bitcnt - 3'd1;
            end
            DATA_ACK: state_nxt = STOP;
            STOP: begin
              state_nxt = IDLE;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
          endcase
        end
      end
    end

    // Pad values are derived from the upcoming state so scl/sda stay registered.
    abyte_nxt = {addr_nxt, 1'b0};
    bit_nxt   = (state_nxt == ADDR) ? abyte_nxt[bitcnt_nxt] : wdata_nxt[bitcnt_nxt];
    unique case (state_nxt)
      START: begin
        scl_nxt = (qtr_nxt != 2'd3);
        oe_nxt  = (qtr_nxt != 2'd0);
      end
      ADDR, DATA: begin
        scl_nxt = (qtr_nxt == 2'd1) || (qtr_nxt == 2'd2);
        oe_nxt  = ~bit_nxt;
      end
      ADDR_ACK, DATA_ACK: begin
        scl_nxt = (qtr_nxt == 2'd1) || (qtr_nxt == 2'd2);
        oe_nxt  = 1'b0;
      end
      STOP: begin
        scl_nxt = (qtr_nxt != 2'd0);
        oe_nxt  = (qtr_nxt <= 2'd1);
      end
      default: begin
        scl_nxt = 1'b1;
        oe_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_master_wr.sv
// Bench for i2c_master_wr: bus monitor + ACKing slave at 7'h51, table, random and corner sequences.
module tb_i2c_master_wr;

  localparam int unsigned CD = 4;
  localparam logic [6:0]  SLAVE_ADDR = 7'h51;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] addr = 7'd0;
  logic [7:0] wdata = 8'd0;
  logic       busy, done, nack, scl;
  wire        sda_bus;

  logic       slv_drv = 1'b0;
  logic       ack_data = 1'b1;

  pullup (sda_bus);
  assign sda_bus = slv_drv ? 1'b0 : 1'bz;

  i2c_master_wr #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .nack(nack), .scl(scl), .sda(sda_bus)
  );

  always #5 clk = ~clk;

  // Bus monitor and slave: bits seen on SCL rises, START/STOP conditions, ACK driving.
  logic       pscl = 1'b1, psda = 1'b1;
  int         rises = 0, start_cnt = 0, stop_cnt = 0;
  logic [7:0] rx_byte = 8'd0;
  logic       bits[$];

  always @(negedge clk) begin
    pscl <= scl;
    psda <= sda_bus;
    if (rst) begin
      slv_drv <= 1'b0;
      rises   <= 0;
    end else begin
      if (pscl && scl && psda && !sda_bus) begin
        start_cnt <= start_cnt + 1;
        bits.delete();
        rises   <= 0;
        slv_drv <= 1'b0;
      end else if (pscl && scl && !psda && sda_bus) begin
        stop_cnt <= stop_cnt + 1;
      end
      if (!pscl && scl) begin
        bits.push_back(sda_bus);
        rises <= rises + 1;
        if (rises < 8) rx_byte <= {rx_byte[6:0], sda_bus};
      end
      if (pscl && !scl) begin
        if (rises == 8)       slv_drv <= (rx_byte[7:1] == SLAVE_ADDR);
        else if (rises == 17) slv_drv <= ack_data;
        else                  slv_drv <= 1'b0;
      end
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: expected outcome from the protocol rules.
  function automatic int ref_busy(input logic [6:0] a);
    return (a == SLAVE_ADDR) ? 80 * CD : 44 * CD;
  endfunction

  function automatic logic ref_nack(input logic [6:0] a, input logic ackd);
    return (a != SLAVE_ADDR) || !ackd;
  endfunction

  task automatic check_bits(input string tag, input logic [6:0] a, input logic [7:0] d, input logic ackd);
    logic eq[$];
    int   bad = 0;
    for (int i = 6; i >= 0; i--) eq.push_back(a[i]);
    eq.push_back(1'b0);
    eq.push_back(a != SLAVE_ADDR);
    if (a == SLAVE_ADDR) begin
      for (int i = 7; i >= 0; i--) eq.push_back(d[i]);
      eq.push_back(!ackd);
    end
    eq.push_back(1'b0);
    chk($sformatf("%s_bitcount", tag), bits.size(), eq.size());
    for (int i = 0; i < eq.size() && i < bits.size(); i++)
      if (bits[i] !== eq[i]) bad++;
    chk($sformatf("%s_bits", tag), bad, 0);
  endtask

  task automatic run_txn(input string tag, input logic [6:0] a, input logic [7:0] d,
                         input logic ackd, input logic glitch,
                         input logic exp_nack, input int exp_busy);
    int s0, p0, k, bcnt, done_k;
    s0 = start_cnt;
    p0 = stop_cnt;
    @(negedge clk);
    ack_data = ackd;
    start = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("%s_busy_rise", tag), int'(busy), 1);
    k = 1; bcnt = 0; done_k = 0;
    while (done_k == 0 && k < 2000) begin
      if (busy) bcnt++;
      if (done) done_k = k;
      if (glitch && k == 50) begin
        start = 1'b1; addr = ~a; wdata = ~d;
      end
      if (glitch && k == 51) start = 1'b0;
      if (done_k == 0) begin
        @(negedge clk);
        k++;
      end
    end
    chk($sformatf("%s_done_cycle", tag), done_k, exp_busy + 1);
    chk($sformatf("%s_busy_cycles", tag), bcnt, exp_busy);
    chk($sformatf("%s_nack", tag), int'(nack), int'(exp_nack));
    check_bits(tag, a, d, ackd);
    chk($sformatf("%s_starts", tag), start_cnt - s0, 1);
    chk($sformatf("%s_stops", tag), stop_cnt - p0, 1);
    @(negedge clk);
    chk($sformatf("%s_done_width", tag), int'(done), 0);
    chk($sformatf("%s_idle_scl", tag), int'(scl), 1);
    chk($sformatf("%s_idle_sda", tag), int'(sda_bus), 1);
  endtask

  typedef struct {
    logic [6:0] a;
    logic [7:0] d;
    logic       ackd;
    logic       glitch;
    logic       exp_nack;
    int         exp_busy;
  } vec_t;

  initial begin
    vec_t vt[6];
    int   s0, p0, k, drops;
    logic [6:0] ra;
    logic [7:0] rd;
    logic       rk;

    vt[0] = '{7'h51, 8'hA5, 1'b1, 1'b0, 1'b0, 320};
    vt[1] = '{7'h22, 8'h3C, 1'b1, 1'b0, 1'b1, 176};
    vt[2] = '{7'h51, 8'h0F, 1'b0, 1'b0, 1'b1, 320};
    vt[3] = '{7'h51, 8'hC3, 1'b1, 1'b1, 1'b0, 320};
    vt[4] = '{7'h51, 8'h00, 1'b1, 1'b0, 1'b0, 320};
    vt[5] = '{7'h50, 8'hFF, 1'b1, 1'b0, 1'b1, 176};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_nack", int'(nack), 0);
    chk("rst_scl", int'(scl), 1);
    chk("rst_sda", int'(sda_bus), 1);

    for (int i = 0; i < 6; i++)
      run_txn($sformatf("vec%0d", i), vt[i].a, vt[i].d, vt[i].ackd, vt[i].glitch,
              vt[i].exp_nack, vt[i].exp_busy);

    for (int i = 0; i < 6; i++) begin
      ra = ($urandom_range(0, 1) == 1) ? SLAVE_ADDR : 7'($urandom);
      rd = 8'($urandom);
      rk = 1'($urandom_range(0, 1));
      run_txn($sformatf("rnd%0d", i), ra, rd, rk, 1'b0, ref_nack(ra, rk), ref_busy(ra));
    end

    // Back-to-back: start held across done.
    s0 = start_cnt; p0 = stop_cnt;
    @(negedge clk);
    ack_data = 1'b1; start = 1'b1; addr = SLAVE_ADDR; wdata = 8'h96;
    k = 0;
    while (!done && k < 2000) begin @(negedge clk); k++; end
    chk("b2b_first_done", int'(done), 1);
    chk("b2b_gap_scl", int'(scl), 1);
    @(negedge clk);
    chk("b2b_rebusy", int'(busy), 1);
    chk("b2b_start_q0_scl", int'(scl), 1);
    start = 1'b0;
    k = 0; drops = 0;
    while (!done && k < 2000) begin
      if (!busy) drops++;
      @(negedge clk); k++;
    end
    chk("b2b_second_done", int'(done), 1);
    chk("b2b_second_len", k, 80 * CD);
    chk("b2b_busy_drops", drops, 0);
    chk("b2b_nack", int'(nack), 0);
    check_bits("b2b", SLAVE_ADDR, 8'h96, 1'b1);
    chk("b2b_starts", start_cnt - s0, 2);
    chk("b2b_stops", stop_cnt - p0, 2);
    @(negedge clk);

    // Reset during DATA bit 3, quarter 1.
    p0 = stop_cnt;
    @(negedge clk);
    ack_data = 1'b1; start = 1'b1; addr = SLAVE_ADDR; wdata = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 230; i++) @(negedge clk);
    chk("rst_mid_scl_before", int'(scl), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_scl", int'(scl), 1);
    chk("rst_mid_sda", int'(sda_bus), 1);
    chk("rst_mid_busy", int'(busy), 0);
    drops = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) drops++;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) drops++;
    end
    chk("rst_mid_no_done", drops, 0);
    chk("rst_mid_no_stop", stop_cnt - p0, 0);
    chk("rst_mid_nack", int'(nack), 0);
    run_txn("post_rst", SLAVE_ADDR, 8'h3E, 1'b1, 1'b0, 1'b0, 80 * CD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_wr.md
I2C_MASTER_WR -- requirements
Module: i2c_master_wr

Interface
REQ-001 SHALL have parameter CLK_DIV, default 250: clk cycles per SCL quarter-period; legal range 2..65535.
REQ-002 SHALL have port clk input 1: system clock; all logic on posedge.
REQ-003 SHALL have port rst input 1: reset, asynchronous and active-high.
REQ-004 SHALL have port start input 1: request a write transaction; sampled on the clk posedge.
REQ-005 SHALL have port addr input 7: 7-bit target address.
REQ-006 SHALL have port wdata input 8: data byte to write.
REQ-007 SHALL have port busy output 1: high while a transaction is in progress.
REQ-008 SHALL have port done output 1: one-clk pulse when a transaction ends.
REQ-009 SHALL have port nack output 1: status flag; high when the last transaction was not acknowledged.
REQ-010 SHALL have port scl output 1: I2C clock, push-pull, single master.
REQ-011 SHALL have port sda inout 1: I2C data, open-drain; either 0 or z, never driven 1 (external pull-up).

Function
REQ-012 SHALL generate a quarter tick every CLK_DIV clk cycles while busy; the divider is held at 0 when idle.
REQ-013 SHALL accept start only in IDLE, and SHALL latch addr and wdata on the accept edge; busy SHALL rise on the next cycle.
REQ-014 SHALL ignore start while busy; latched values SHALL NOT change mid-transaction.
REQ-015 SHALL implement the states IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, and each state after IDLE SHALL last a whole number of quarter ticks.
REQ-016 START SHALL last 4 quarters. q0: SCL=1, SDA released. q1–q2: SCL=1, SDA=0. q3: SCL=0, SDA=0.
REQ-017 Every bit SHALL last 4 quarters. q0: SCL=0, SDA set. q1–q2: SCL=1. q3: SCL=0. SDA SHALL change only in q0.
REQ-018 ADDR SHALL send 8 bits MSB first: addr[6:0] followed by R/W=0.
REQ-019 DATA SHALL send wdata[7:7..0] MSB first, 8 bits.
REQ-020 In ADDR_ACK and DATA_ACK, SDA SHALL be released for the whole bit, and SDA SHALL be sampled once at the end of q1.
REQ-021 A sampled 0 SHALL count as ACK; a sampled 1 or z SHALL count as NACK.
REQ-022 ADDR_ACK with ACK SHALL go to DATA; ADDR_ACK with NACK SHALL set nack and go directly to STOP, skipping DATA.
REQ-023 DATA_ACK SHALL go to STOP; NACK in DATA_ACK SHALL set nack.
REQ-024 STOP SHALL last 4 quarters. q0: SCL=0, SDA=0. q1: SCL=1, SDA=0. q2–q3: SCL=1, SDA released.
REQ-025 At the end of STOP, the block SHALL return to IDLE.
REQ-026 busy SHALL be high for exactly 80*CLK_DIV cycles on an ACKed transaction, and for 44*CLK_DIV cycles on an address NACK.
REQ-027 done SHALL be high for exactly one cycle, namely the first cycle with busy=0 after a transaction.
REQ-028 nack SHALL be cleared on start accept, and SHALL hold its value until the next accept.
REQ-029 In IDLE, scl SHALL be 1 and SDA SHALL be released.
REQ-030 A start asserted in the same cycle that done is high SHALL be accepted.
REQ-031 The bit counter SHALL be 3 bits, count 7 down to 0, and be reloaded at each byte.

Reset
REQ-032 rst SHALL act immediately, independent of clk.
REQ-033 On rst: state=IDLE, divider=0, bit counter=7, busy=0, done=0, nack=0, scl=1, SDA released.
REQ-034 rst asserted mid-transaction SHALL abort the transaction without generating a STOP and without pulsing done.
REQ-035 After rst deasserts, the first accepted start SHALL begin a clean START.

Verification (CLK_DIV=4; slave model with address 7'h51)
REQ-036 start, addr=7'h51, wdata=8'hA5, slave ACKs both bytes -> SDA bits 1010001_0 then 10100101, done at cycle 321 after accept, nack=0.
REQ-037 start, addr=7'h22, no ACK -> no DATA bits driven, STOP follows ADDR_ACK, busy high 176 cycles, done pulse, nack=1.
REQ-038 address ACKed, data NACKed -> full 320-cycle busy window, nack=1.
REQ-039 start pulsed again mid-transaction with new addr/wdata -> ignored, original values sent.
REQ-040 start held high across done -> back-to-back transactions, scl=1 between STOP and the next START q0.
REQ-041 rst asserted during the DATA bit-3 q1 -> same-cycle scl=1, SDA=z, busy=0, no done pulse.
REQ-042 Every scenario SHALL pass these checkers: SDA is never driven 1, and SDA never changes while SCL=1 except in START and STOP.
